// File: rtl/vec_seq_ctrl_pkg.sv
// vec_pkg: shared encodings and state enum for the vector sequencing controller.
package vec_pkg;
    localparam logic [1:0] VOP_LOAD  = 2'b00;
    localparam logic [1:0] VOP_STORE = 2'b01;
    localparam logic [1:0] VOP_ADD   = 2'b10;
    localparam logic [2:0] MEMIN_LANE0 = 3'b000;
    localparam logic [2:0] MEMIN_LANE1 = 3'b001;
    localparam logic [2:0] MEMIN_LANE2 = 3'b010;
    localparam logic [2:0] MEMIN_LANE3 = 3'b011;
    localparam logic [2:0] MEMIN_R1    = 3'b100;
    typedef enum logic [3:0] {
        S_IDLE, S_BASE, S_RD, S_CAPT, S_WR, S_XLD, S_ADD, S_WB, S_DONE
    } state_t;
endpackage

// File: rtl/vec_seq_ctrl_if.sv
// vec_seq_ctrl_if: start/done handshake from the main FSM plus datapath control strobes.
interface vec_seq_ctrl_if;
    logic       start;
    logic [1:0] op;
    logic       busy;
    logic       done;
    logic       R2Sel;
    logic       R2Ld;
    logic       AddrSel;
    logic       MemRead;
    logic       MemWrite;
    logic [2:0] MemIn;
    logic       X1Load;
    logic       X2Load;
    logic       VoutSel;
    logic       T0Ld;
    logic       T1Ld;
    logic       T2Ld;
    logic       T3Ld;
    logic       VRFWrite;
    modport master (
        output start, op,
        input  busy, done, R2Sel, R2Ld, AddrSel, MemRead, MemWrite, MemIn,
               X1Load, X2Load, VoutSel, T0Ld, T1Ld, T2Ld, T3Ld, VRFWrite
    );
    modport slave (
        input  start, op,
        output busy, done, R2Sel, R2Ld, AddrSel, MemRead, MemWrite, MemIn,
               X1Load, X2Load, VoutSel, T0Ld, T1Ld, T2Ld, T3Ld, VRFWrite
    );
endinterface

// File: rtl/vec_seq_ctrl.sv
// vec_seq_ctrl: Moore FSM sequencing VLOAD/VSTORE/VADD over the vector datapath.
module vec_seq_ctrl
    import vec_pkg::*;
#(
    parameter int MEM_RD_LAT = 1
) (
    input  logic         clock,
    input  logic         reset,
    vec_seq_ctrl_if.slave bus
);
    state_t     r_state, w_next;
    logic [1:0] r_idx, w_idx;
    logic [1:0] r_wcnt, w_wcnt;
    logic       w_rd, w_capt, w_wr, w_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_wcnt  <= 2'd0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx;
            r_wcnt  <= w_wcnt;
        end
    end

    always_comb begin
        w_next = r_state;
        w_idx  = r_idx;
        w_wcnt = r_wcnt;
        case (r_state)
            S_IDLE: if (bus.start) begin
                w_idx  = 2'd0;
                w_wcnt = 2'd0;
                w_next = (bus.op == VOP_LOAD || bus.op == VOP_STORE) ? S_BASE :
                         (bus.op == VOP_ADD) ? S_XLD : S_DONE;
            end
            S_BASE: w_next = (bus.op == VOP_STORE) ? S_WR : S_RD;
            S_RD: begin
                w_next = (r_wcnt == 2'(MEM_RD_LAT - 1)) ? S_CAPT : S_RD;
                w_wcnt = (r_wcnt == 2'(MEM_RD_LAT - 1)) ? 2'd0 : r_wcnt + 2'd1;
            end
            S_CAPT: begin
                w_next = w_last ? S_WB : S_RD;
                w_idx  = w_last ? r_idx : r_idx + 2'd1;
            end
            S_WR: begin
                w_next = w_last ? S_IDLE : S_WR;
                w_idx  = w_last ? r_idx : r_idx + 2'd1;
            end
            S_XLD:   w_next = S_ADD;
            S_ADD:   w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_rd   = (r_state == S_RD);
    assign w_capt = (r_state == S_CAPT);
    assign w_wr   = (r_state == S_WR);
    assign w_last = (r_idx == 2'd3);

    // Lane 0 is the MSB byte, so T0 captures first on loads.
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_WB) || (r_state == S_DONE) || (w_wr && w_last);
    assign bus.R2Sel    = w_capt || w_wr;
    assign bus.R2Ld     = (r_state == S_BASE) || w_capt || w_wr;
    assign bus.AddrSel  = !(w_rd || w_capt || w_wr);
    assign bus.MemRead  = w_rd;
    assign bus.MemWrite = w_wr;
    assign bus.MemIn    = w_wr ? {1'b0, r_idx} : MEMIN_R1;
    assign bus.X1Load   = (r_state == S_XLD) || (r_state == S_BASE && bus.op == VOP_STORE);
    assign bus.X2Load   = (r_state == S_XLD);
    assign bus.VoutSel  = w_capt;
    assign bus.T0Ld     = (r_state == S_ADD) || (w_capt && r_idx == 2'd0);
    assign bus.T1Ld     = (r_state == S_ADD) || (w_capt && r_idx == 2'd1);
    assign bus.T2Ld     = (r_state == S_ADD) || (w_capt && r_idx == 2'd2);
    assign bus.T3Ld     = (r_state == S_ADD) || (w_capt && r_idx == 2'd3);
    assign bus.VRFWrite = (r_state == S_WB);
endmodule

// File: tb/tb_vec_seq_ctrl.sv
// tb_vec_seq_ctrl: checks two controller instances (read latency 1 and 2) against a cycle schedule model.
module tb_vec_seq_ctrl;
    import vec_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [7:0]  base = 8'h00;
    logic [31:0] va = 32'h0, vb = 32'h0;
    logic [31:0] exp_vd = 32'h0;
    logic [7:0]  mem [256];
    time         t_acc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clock = ~clock;

    function automatic int op_len(input logic [1:0] o, input int lat);
        return (o == 2'b00) ? 2 + 4 * (lat + 1) : (o == 2'b01) ? 5 : (o == 2'b10) ? 3 : 1;
    endfunction

    // Expected strobes for cycle k after the accept edge (k=0 means idle).
    function automatic logic [17:0] exp_out(input logic [1:0] o, input int k, input int lat);
        logic bz = 0, dn = 0, r2s = 0, r2l = 0, as = 1, mr = 0, mw = 0, x1l = 0, x2l = 0, vs = 0, vrf = 0;
        logic [2:0] mi = 3'b100;
        logic [3:0] tl = 4'b0;
        int n = op_len(o, lat);
        if (k > 0) begin
            bz = 1;
            if (o == 2'b00) begin
                if (k == 1) r2l = 1;
                else if (k == n) begin vrf = 1; dn = 1; end
                else if ((k - 2) % (lat + 1) < lat) begin as = 0; mr = 1; end
                else begin
                    as = 0; vs = 1; r2s = 1; r2l = 1;
                    tl[3 - (k - 2) / (lat + 1)] = 1'b1;
                end
            end else if (o == 2'b01) begin
                if (k == 1) begin r2l = 1; x1l = 1; end
                else begin as = 0; mw = 1; mi = 3'(k - 2); r2s = 1; r2l = 1; dn = (k == 5); end
            end else if (o == 2'b10) begin
                if (k == 1) begin x1l = 1; x2l = 1; end
                else if (k == 2) tl = 4'hF;
                else begin vrf = 1; dn = 1; end
            end else dn = 1;
        end
        return {bz, dn, r2s, r2l, as, mr, mw, mi, x1l, x2l, vs, tl, vrf};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_i
        localparam int LAT = g + 1;
        vec_seq_ctrl_if u_if();
        assign u_if.start = start;
        assign u_if.op    = op;
        vec_seq_ctrl #(.MEM_RD_LAT(LAT)) u_dut (.clock(clock), .reset(reset), .bus(u_if));

        logic [7:0]  r2 = 8'h00;
        logic [31:0] x1 = 32'h0, x2 = 32'h0, t = 32'h0;
        int          rdrun = 0, vrf_n = 0, rd_rise = 0, k = 0;
        logic [1:0]  kop = 2'b00;
        logic        prev_mr = 1'b0;
        time         done_t = 0;
        logic [17:0] a, e;
        wire  [7:0]  addr = u_if.AddrSel ? 8'h00 : r2;
        wire  [7:0]  memwire = (rdrun >= LAT) ? mem[addr] : 8'hEE;
        wire  [31:0] sum = {x1[31:24] + x2[31:24], x1[23:16] + x2[23:16], x1[15:8] + x2[15:8], x1[7:0] + x2[7:0]};
        wire  [7:0]  wdat = (u_if.MemIn[1:0] == 2'd0) ? x1[31:24] : (u_if.MemIn[1:0] == 2'd1) ? x1[23:16] :
                            (u_if.MemIn[1:0] == 2'd2) ? x1[15:8] : x1[7:0];

        always @(posedge clock) begin
            if (u_if.R2Ld) r2 <= u_if.R2Sel ? r2 + 8'd1 : base;
            if (u_if.X1Load) x1 <= va;
            if (u_if.X2Load) x2 <= vb;
            if (u_if.T0Ld) t[31:24] <= u_if.VoutSel ? memwire : sum[31:24];
            if (u_if.T1Ld) t[23:16] <= u_if.VoutSel ? memwire : sum[23:16];
            if (u_if.T2Ld) t[15:8]  <= u_if.VoutSel ? memwire : sum[15:8];
            if (u_if.T3Ld) t[7:0]   <= u_if.VoutSel ? memwire : sum[7:0];
            if (g == 0 && u_if.MemWrite) mem[addr] <= wdat;
            rdrun <= u_if.MemRead ? rdrun + 1 : 0;
        end

        always @(negedge clock) begin
            a = {u_if.busy, u_if.done, u_if.R2Sel, u_if.R2Ld, u_if.AddrSel, u_if.MemRead, u_if.MemWrite,
                 u_if.MemIn, u_if.X1Load, u_if.X2Load, u_if.VoutSel, u_if.T0Ld, u_if.T1Ld, u_if.T2Ld,
                 u_if.T3Ld, u_if.VRFWrite};
            e = exp_out(kop, k, LAT);
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL ctl lat%0d k=%0d op=%0d got %h want %h", LAT, k, kop, a, e);
            end
            if (u_if.VRFWrite) begin
                vrf_n++;
                vectors++;
                if (t !== exp_vd) begin
                    miscompares++;
                    $display("FAIL vdataw lat%0d got %h want %h", LAT, t, exp_vd);
                end
            end
            if (u_if.done) done_t = $time;
            if (u_if.MemRead && !prev_mr) rd_rise++;
            prev_mr = u_if.MemRead;
            if (reset) k = 0;
            else if (k == 0 && start) begin k = 1; kop = op; end
            else if (k == op_len(kop, LAT)) k = 0;
            else if (k > 0) k++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    function automatic int dcyc(input time dt);
        return (dt > t_acc) ? int'((dt - t_acc + 5) / 10) : 0;
    endfunction

    task automatic run(input logic [1:0] o, input logic [7:0] b, input logic [31:0] a1, input logic [31:0] b1,
                       input int hold, input int rst_at);
        bit idle = 0;
        @(posedge clock); #1;
        op = o; base = b; va = a1; vb = b1; start = 1'b1;
        @(posedge clock); t_acc = $time; #1;
        for (int c = 1; c <= 60 && !idle; c++) begin
            reset = (c == rst_at);
            if (c == hold) start = 1'b0;
            @(negedge clock);
            idle = !g_i[0].u_if.busy && !g_i[1].u_if.busy && !start && !reset;
            if (!idle) begin @(posedge clock); #1; end
        end
        if (!idle) begin
            miscompares++;
            $display("FAIL timeout op=%0d", o);
        end
    endtask

    initial begin
        int v0, v1, r0, r1;
        logic [7:0] d [4];
        logic [1:0] o;
        logic [7:0] b;
        logic [31:0] a1, b1;
        int hold, rst_at;
        for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", 32'(g_i[0].u_if.busy), 0);
        chk("rst_addrsel", 32'(g_i[0].u_if.AddrSel), 1);
        chk("rst_memin", 32'(g_i[1].u_if.MemIn), 4);

        mem[8'h40] <= 8'h11; mem[8'h41] <= 8'h22; mem[8'h42] <= 8'h33; mem[8'h43] <= 8'h44;
        exp_vd = 32'h11223344;
        v0 = g_i[0].vrf_n; v1 = g_i[1].vrf_n; r0 = g_i[0].rd_rise; r1 = g_i[1].rd_rise;
        run(VOP_LOAD, 8'h40, 0, 0, 1, 0);
        chk("load_done_lat1", dcyc(g_i[0].done_t), 10);
        chk("load_done_lat2", dcyc(g_i[1].done_t), 14);
        chk("load_r2_lat1", 32'(g_i[0].r2), 32'h44);
        chk("load_r2_lat2", 32'(g_i[1].r2), 32'h44);
        chk("load_rd_bursts1", g_i[0].rd_rise - r0, 4);
        chk("load_rd_bursts2", g_i[1].rd_rise - r1, 4);
        chk("load_vrf1", g_i[0].vrf_n - v0, 1);
        chk("load_vrf2", g_i[1].vrf_n - v1, 1);

        run(VOP_STORE, 8'hFE, 32'hA1B2C3D4, 0, 1, 0);
        chk("st_memFE", 32'(mem[8'hFE]), 32'hA1);
        chk("st_memFF", 32'(mem[8'hFF]), 32'hB2);
        chk("st_mem00", 32'(mem[8'h00]), 32'hC3);
        chk("st_mem01", 32'(mem[8'h01]), 32'hD4);
        chk("st_done", dcyc(g_i[0].done_t), 5);
        chk("st_r2", 32'(g_i[0].r2), 32'h02);

        exp_vd = 32'h02008012;
        v0 = g_i[0].vrf_n;
        run(VOP_ADD, 8'h00, 32'h01FF7F10, 32'h01010102, 4, 0);
        chk("add_done", dcyc(g_i[0].done_t), 3);
        chk("add_vrf_once", g_i[0].vrf_n - v0, 1);

        v0 = g_i[0].vrf_n;
        run(2'b11, 8'h00, 0, 0, 1, 0);
        chk("rsv_done", dcyc(g_i[0].done_t), 1);
        chk("rsv_novrf", g_i[0].vrf_n - v0, 0);

        exp_vd = 32'h11223344;
        v0 = g_i[0].vrf_n; v1 = g_i[1].vrf_n;
        run(VOP_LOAD, 8'h40, 0, 0, 1, 6);
        chk("rst_mid_busy", 32'(g_i[1].u_if.busy), 0);
        chk("rst_mid_addrsel", 32'(g_i[1].u_if.AddrSel), 1);
        chk("rst_mid_memin", 32'(g_i[0].u_if.MemIn), 4);
        chk("rst_mid_novrf", g_i[0].vrf_n - v0 + g_i[1].vrf_n - v1, 0);
        run(VOP_LOAD, 8'h40, 0, 0, 1, 0);
        chk("reload_vrf", g_i[0].vrf_n - v0 + g_i[1].vrf_n - v1, 2);

        for (int it = 0; it < 80; it++) begin
            o = 2'($urandom_range(0, 3));
            b = 8'($urandom);
            a1 = $urandom; b1 = $urandom;
            hold = $urandom_range(1, 6);
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 12) : 0;
            for (int i = 0; i < 4; i++) begin
                d[i] = 8'($urandom);
                mem[b + 8'(i)] <= d[i];
            end
            exp_vd = (o == VOP_ADD) ? {a1[31:24] + b1[31:24], a1[23:16] + b1[23:16], a1[15:8] + b1[15:8],
                                       a1[7:0] + b1[7:0]} : {d[0], d[1], d[2], d[3]};
            run(o, b, a1, b1, hold, rst_at);
            if (o == VOP_STORE && rst_at == 0) begin
                chk("rnd_st0", 32'(mem[b]), 32'(a1[31:24]));
                chk("rnd_st1", 32'(mem[b + 8'd1]), 32'(a1[23:16]));
                chk("rnd_st2", 32'(mem[b + 8'd2]), 32'(a1[15:8]));
                chk("rnd_st3", 32'(mem[b + 8'd3]), 32'(a1[7:0]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
